// File: rtl/sram_pingpong_ctrl.sv
// rtl/sram_pingpong_ctrl.sv - double-buffered T-sequence SRAM: shadow bank loads while active bank serves the PE array
// Optional define SRAMC_BYPASS_EN forwards a same-cycle write-back to a read of the same active address.
module sram_pingpong_ctrl #(
  parameter int SYM_BITS = 2,
  parameter int SYM_PER_WORD = 7,
  parameter int SCORE_BITS = 10,
  parameter int DEPTH = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  localparam int T_W = SYM_PER_WORD * SYM_BITS,
  localparam int WORD_W = 1 + SYM_PER_WORD * (SYM_BITS + 2 * SCORE_BITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load_valid,
  input  logic              i_load_last,
  input  logic [T_W-1:0]    i_t,
  output logic              o_load_ready,
  input  logic              i_swap,
  output logic              o_shadow_full,
  input  logic              i_pe_request,
  output logic [WORD_W-1:0] o_request_data,
  input  logic              i_pe_send,
  input  logic [WORD_W-1:0] i_send_data,
  output logic              o_busy,
  output logic [ADDR_W:0]   o_t_size,
  output logic              o_pass_done
);
  localparam int FIELD_W = SYM_BITS + 2 * SCORE_BITS;
  localparam int SZ_W = ADDR_W + 1;

  typedef enum logic [1:0] {L_IDLE, L_FILL, L_FULL} lstate_e;

  lstate_e             state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   rptr_q, rptr_d;
  logic [ADDR_W-1:0]   wbptr_q, wbptr_d;
  logic [SZ_W-1:0]     shadow_size_q, shadow_size_d;
  logic [SZ_W-1:0]     t_size_q, t_size_d;
  logic                active_q, active_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic                pass_done_q, pass_done_d;

  logic [WORD_W-1:0]   mem_q [2][DEPTH];

  logic                load_we, pe_we, has_seq, swap_fire;
  logic [ADDR_W-1:0]   load_addr, last_addr;
  logic [WORD_W-1:0]   load_word;

  // Loaded words carry valid=1 and zeroed V/F scores for every symbol.
  always_comb begin
    load_word = '0;
    load_word[WORD_W-1] = 1'b1;
    for (int k = 0; k < SYM_PER_WORD; k++) begin
      load_word[k*FIELD_W + 2*SCORE_BITS +: SYM_BITS] = i_t[k*SYM_BITS +: SYM_BITS];
    end
  end

  always_comb begin
    state_d       = state_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    wbptr_d       = wbptr_q;
    shadow_size_d = shadow_size_q;
    t_size_d      = t_size_q;
    active_d      = active_q;
    rdata_d       = '0;
    pass_done_d   = 1'b0;
    load_we       = 1'b0;
    load_addr     = (state_q == L_IDLE) ? '0 : wptr_q;
    has_seq       = (t_size_q != '0);
    last_addr     = ADDR_W'(t_size_q - SZ_W'(1));
    pe_we         = i_pe_send && has_seq;
    swap_fire     = i_swap && (state_q == L_FULL) && !i_pe_request && !i_pe_send;

    if (i_pe_request && has_seq) begin
      rdata_d = mem_q[active_q][rptr_q];
`ifdef SRAMC_BYPASS_EN
      if (pe_we && (wbptr_q == rptr_q)) rdata_d = i_send_data;
`endif
      rptr_d = (rptr_q == last_addr) ? '0 : rptr_q + ADDR_W'(1);
    end

    if (pe_we) begin
      pass_done_d = (wbptr_q == last_addr);
      wbptr_d = (wbptr_q == last_addr) ? '0 : wbptr_q + ADDR_W'(1);
    end

    case (state_q)
      L_IDLE, L_FILL: begin
        if (i_load_valid) begin
          load_we = 1'b1;
          wptr_d  = load_addr + ADDR_W'(1);
          if (i_load_last || (load_addr == ADDR_W'(DEPTH - 1))) begin
            state_d       = L_FULL;
            shadow_size_d = SZ_W'(load_addr) + SZ_W'(1);
          end else begin
            state_d = L_FILL;
          end
        end
      end
      L_FULL: begin
        // swap_fire excludes PE traffic, so the pointer resets cannot collide with it
        if (swap_fire) begin
          active_d = ~active_q;
          t_size_d = shadow_size_q;
          rptr_d   = '0;
          wbptr_d  = '0;
          wptr_d   = '0;
          state_d  = L_IDLE;
        end
      end
      default: state_d = L_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= L_IDLE;
      wptr_q        <= '0;
      rptr_q        <= '0;
      wbptr_q       <= '0;
      shadow_size_q <= '0;
      t_size_q      <= '0;
      active_q      <= 1'b0;
      rdata_q       <= '0;
      pass_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      wbptr_q       <= wbptr_d;
      shadow_size_q <= shadow_size_d;
      t_size_q      <= t_size_d;
      active_q      <= active_d;
      rdata_q       <= rdata_d;
      pass_done_q   <= pass_done_d;
    end
  end

  // Banks are never cleared; loads and write-backs always target different banks.
  always_ff @(posedge clk) begin
    if (load_we) mem_q[~active_q][load_addr] <= load_word;
    if (pe_we) mem_q[active_q][wbptr_q] <= i_send_data;
  end

  assign o_load_ready   = (state_q != L_FULL);
  assign o_shadow_full  = (state_q == L_FULL);
  assign o_busy         = (state_q == L_FILL);
  assign o_t_size       = t_size_q;
  assign o_request_data = rdata_q;
  assign o_pass_done    = pass_done_q;
endmodule

// File: tb/tb_sram_pingpong_ctrl.sv
// tb/tb_sram_pingpong_ctrl.sv - self-checking bench for sram_pingpong_ctrl (honours SRAMC_BYPASS_EN)
module tb_sram_pingpong_ctrl;
  localparam int W = 155;
  localparam int D = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_load_valid, i_load_last, i_swap, i_pe_request, i_pe_send;
  logic [13:0]   i_t;
  logic [W-1:0]  i_send_data;
  logic          o_load_ready, o_shadow_full, o_busy, o_pass_done;
  logic [W-1:0]  o_request_data;
  logic [8:0]    o_t_size;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_act [D];
  logic [W-1:0] m_sh [D];
  int m_sz, m_rp, m_wp, m_shn;

  typedef struct {
    logic [13:0] t;
    logic        last;
    logic        exp_busy;
    logic        exp_full;
    logic        exp_ready;
  } ld_vec_t;
  ld_vec_t ld_tbl [3];

  always #5 clk = ~clk;

  sram_pingpong_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_load_valid(i_load_valid), .i_load_last(i_load_last), .i_t(i_t),
    .o_load_ready(o_load_ready), .i_swap(i_swap), .o_shadow_full(o_shadow_full),
    .i_pe_request(i_pe_request), .o_request_data(o_request_data),
    .i_pe_send(i_pe_send), .i_send_data(i_send_data),
    .o_busy(o_busy), .o_t_size(o_t_size), .o_pass_done(o_pass_done)
  );

  function automatic logic [W-1:0] mk_word(input logic [13:0] t, input logic [9:0] v, input logic [9:0] f);
    logic [W-1:0] w;
    w = '0;
    w[W-1] = 1'b1;
    for (int k = 0; k < 7; k++) w[k*22 +: 22] = {t[k*2 +: 2], v, f};
    return w;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    m_sz = 0; m_rp = 0; m_wp = 0; m_shn = 0;
    exp_q.delete();
  endtask

  task automatic drive_beat(input logic [13:0] t, input logic last);
    i_load_valid = 1'b1;
    i_t = t;
    i_load_last = last;
    m_sh[m_shn] = mk_word(t, 10'd0, 10'd0);
    m_shn++;
  endtask

  task automatic do_swap();
    i_swap = 1'b1;
    step();
    i_swap = 1'b0;
    m_sz = m_shn;
    for (int i = 0; i < m_shn; i++) m_act[i] = m_sh[i];
    m_rp = 0; m_wp = 0; m_shn = 0;
    chk("t_size_after_swap", o_t_size, m_sz);
  endtask

  task automatic pe_cycle(input logic req, input logic snd, input logic [W-1:0] sd);
    logic [W-1:0] e;
    logic pd;
    i_pe_request = req;
    i_pe_send = snd;
    i_send_data = sd;
    pd = 1'b0;
    if (req && m_sz != 0) begin
      e = m_act[m_rp];
`ifdef SRAMC_BYPASS_EN
      if (snd && m_wp == m_rp) e = sd;
`endif
      exp_q.push_back(e);
      m_rp = (m_rp == m_sz - 1) ? 0 : m_rp + 1;
    end
    if (snd && m_sz != 0) begin
      m_act[m_wp] = sd;
      pd = (m_wp == m_sz - 1);
      m_wp = (m_wp == m_sz - 1) ? 0 : m_wp + 1;
    end
    step();
    i_pe_request = 1'b0;
    i_pe_send = 1'b0;
    if (exp_q.size() != 0) chk("rdata", o_request_data, exp_q.pop_front());
    else chk("rdata_idle", o_request_data, 0);
    chk("pass_done", o_pass_done, pd);
  endtask

  initial begin
    logic [13:0] tv [3];
    tv[0] = 14'h0001; tv[1] = 14'h0002; tv[2] = 14'h3FFF;
    ld_tbl[0] = '{14'h0001, 1'b0, 1'b1, 1'b0, 1'b1};
    ld_tbl[1] = '{14'h0002, 1'b0, 1'b1, 1'b0, 1'b1};
    ld_tbl[2] = '{14'h3FFF, 1'b1, 1'b0, 1'b1, 1'b0};

    i_load_valid = 0; i_load_last = 0; i_swap = 0; i_pe_request = 0; i_pe_send = 0;
    i_t = '0; i_send_data = '0;
    do_reset();
    chk("rst_rdata", o_request_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_full", o_shadow_full, 0);
    chk("rst_pass_done", o_pass_done, 0);
    chk("rst_ready", o_load_ready, 1);
    chk("rst_t_size", o_t_size, 0);

    for (int i = 0; i < 3; i++) begin
      drive_beat(ld_tbl[i].t, ld_tbl[i].last);
      step();
      chk("load_busy", o_busy, ld_tbl[i].exp_busy);
      chk("load_full", o_shadow_full, ld_tbl[i].exp_full);
      chk("load_ready", o_load_ready, ld_tbl[i].exp_ready);
    end
    i_load_valid = 1'b1; i_t = 14'h2AAA; i_load_last = 1'b1;
    step();
    i_load_valid = 1'b0; i_load_last = 1'b0;
    chk("full_ignores_beat", o_shadow_full, 1);

    do_swap();
    chk("swap_full_clear", o_shadow_full, 0);
    chk("swap_ready", o_load_ready, 1);

    for (int i = 0; i < 4; i++) pe_cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) pe_cycle(1'b0, 1'b1, mk_word(tv[i], 10'd5, 10'd5));
    pe_cycle(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) pe_cycle(1'b1, 1'b0, '0);

    drive_beat(14'h1234, 1'b0);
    pe_cycle(1'b1, 1'b0, '0);
    drive_beat(14'h0ABC, 1'b1);
    pe_cycle(1'b1, 1'b0, '0);
    i_load_valid = 1'b0; i_load_last = 1'b0;
    chk("stream_load_full", o_shadow_full, 1);

    i_swap = 1'b1;
    pe_cycle(1'b1, 1'b0, '0);
    i_swap = 1'b0;
    chk("swap_blocked_req_tsize", o_t_size, 3);
    chk("swap_blocked_req_full", o_shadow_full, 1);
    i_swap = 1'b1;
    pe_cycle(1'b0, 1'b1, mk_word(14'h0FF0, 10'd1, 10'd2));
    i_swap = 1'b0;
    chk("swap_blocked_send_tsize", o_t_size, 3);

    do_swap();
    pe_cycle(1'b1, 1'b1, mk_word(14'h1357, 10'd7, 10'd9));
    pe_cycle(1'b1, 1'b0, '0);
    pe_cycle(1'b1, 1'b0, '0);
    pe_cycle(1'b0, 1'b1, mk_word(14'h2468, 10'd3, 10'd4));
    pe_cycle(1'b1, 1'b0, '0);
    pe_cycle(1'b1, 1'b0, '0);

    for (int i = 0; i < D; i++) begin
      drive_beat(14'(i * 37 + 5), 1'b0);
      step();
      if (i == D - 2) begin
        chk("depth_busy_before_last", o_busy, 1);
        chk("depth_full_before_last", o_shadow_full, 0);
      end
    end
    i_load_valid = 1'b0;
    chk("depth_full", o_shadow_full, 1);
    chk("depth_busy_clear", o_busy, 0);
    do_swap();
    pe_cycle(1'b1, 1'b0, '0);
    pe_cycle(1'b1, 1'b0, '0);

    drive_beat(14'h0111, 1'b0);
    step();
    drive_beat(14'h0222, 1'b0);
    step();
    i_load_valid = 1'b0;
    chk("midload_busy", o_busy, 1);
    do_reset();
    chk("midrst_busy", o_busy, 0);
    chk("midrst_ready", o_load_ready, 1);
    chk("midrst_t_size", o_t_size, 0);
    chk("midrst_full", o_shadow_full, 0);
    pe_cycle(1'b1, 1'b0, '0);
    pe_cycle(1'b0, 1'b1, mk_word(14'h3333, 10'd1, 10'd1));

    drive_beat(14'h1A2B, 1'b1);
    step();
    i_load_valid = 1'b0; i_load_last = 1'b0;
    chk("single_beat_full", o_shadow_full, 1);
    chk("single_beat_busy", o_busy, 0);
    do_swap();
    pe_cycle(1'b1, 1'b0, '0);
    pe_cycle(1'b1, 1'b1, mk_word(14'h0C0C, 10'd2, 10'd8));
    pe_cycle(1'b1, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_pingpong_ctrl.md
Name: sram_pingpong_ctrl

Overview:
- Parametrised, double-buffered successor to the single-bank T-sequence SRAM controller in the Smith-Waterman array.
- Holds packed target-sequence words with per-symbol V/F scores, serves them round-robin to the PE array, and takes PE write-backs.
- Two banks: one active bank serves the PE array; the shadow bank loads the next T sequence concurrently, then the banks swap on command.

Parameters:
SYM_BITS, 2, bits per nucleotide symbol
SYM_PER_WORD, 7, symbols packed per SRAM word
SCORE_BITS, 10, width of each V and F score field
DEPTH, 256, words per bank
ADDR_W, 8, clog2(DEPTH)
Derived: T_W = SYM_PER_WORD*SYM_BITS; WORD_W = 1 + SYM_PER_WORD*(SYM_BITS+2*SCORE_BITS)

Ports:
clk  in  1  sole clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
i_load_valid  in  1  load beat valid
i_load_last  in  1  marks final beat of a T sequence
i_t  in  T_W  packed symbols, symbol 0 in LSBs
o_load_ready  out  1  shadow bank accepts load beats
i_swap  in  1  request to make the shadow bank active
o_shadow_full  out  1  shadow bank holds a complete sequence
i_pe_request  in  1  PE requests the next word
o_request_data  out  WORD_W  word returned to PE; MSB = valid
i_pe_send  in  1  PE write-back strobe
i_send_data  in  WORD_W  write-back word
o_busy  out  1  load in progress
o_t_size  out  ADDR_W+1  word count of the active bank
o_pass_done  out  1  one-cycle pulse when the last word of a pass is written back

Behaviour:
- Word format, MSB first: valid; then per symbol k = SYM_PER_WORD-1 down to 0: {sym, V, F}. Loaded words have valid=1 and V=F=0.
- Reset (rst_n=0 at an edge):
  - Load FSM goes to L_IDLE; rptr, wbptr, wptr, shadow_size, o_t_size cleared to 0.
  - o_request_data=0, o_busy=0, o_shadow_full=0, o_pass_done=0, o_load_ready=1; active bank = bank 0.
  - SRAM contents are not cleared. Reset mid-load aborts the load; the partial shadow data is discarded.
- Load FSM:
  - L_IDLE: o_load_ready=1. An accepted beat writes shadow[0], sets wptr=1 and moves to L_FILL.
  - L_FILL: o_busy=1, o_load_ready=1. Each beat writes shadow[wptr] and increments wptr.
  - A beat with i_load_last=1, or the beat at address DEPTH-1, moves to L_FULL with shadow_size = beat address + 1.
  - A single-beat sequence with i_load_last=1 goes L_IDLE -> L_FULL directly, shadow_size=1.
  - L_FULL: o_load_ready=0, o_shadow_full=1. Beats are ignored.
- Swap:
  - i_swap is honoured only in L_FULL and only when i_pe_request=0 and i_pe_send=0 in that cycle; otherwise it is ignored (not queued).
  - Next cycle: active bank flips, o_t_size=shadow_size, rptr=wbptr=0, FSM -> L_IDLE.
- Read:
  - i_pe_request=1 with o_t_size!=0 -> the next cycle o_request_data = active[rptr] (1-cycle latency, registered). rptr increments and wraps to 0 after o_t_size-1.
  - Any cycle not returning data drives o_request_data=0 (valid=0).
- Write-back:
  - i_pe_send=1 -> active[wbptr] <= i_send_data. wbptr increments and wraps like rptr.
  - Writing address o_t_size-1 pulses o_pass_done the next cycle.
  - i_pe_send with o_t_size=0 is ignored.
- Read and write in the same cycle are both served; the banks are dual-ported in behaviour.

Optional Feature:
SRAMC_BYPASS_EN
- Defined: a same-cycle read and write-back to the same active address returns i_send_data on o_request_data.
- Undefined: that read returns the pre-write contents.
- The forwarding path is the only difference between the two builds.

Test Plan:
- Reset, load 3 beats i_t = 0x0001, 0x0002, 0x3FFF with last on beat 3 -> o_busy high 2 cycles, o_shadow_full=1; after i_swap, o_t_size=3.
- After swap, 4 consecutive requests -> words for 0x0001, 0x0002, 0x3FFF, then 0x0001 again (wrap); each valid=1 with all scores 0; 1-cycle latency.
- Write back words tagged V=F=5 for addresses 0..2 -> o_pass_done pulses once after the third write; the next pass reads V=F=5.
- Load a 2-word sequence into the shadow bank while the PE is streaming; assert i_swap while i_pe_request=1 -> ignored; assert again when idle -> o_t_size=2 and rptr restarts at 0.
- Request and send to the same address in one cycle -> returns new data if SRAMC_BYPASS_EN is defined, old data otherwise.
- rst_n=0 after 2 load beats -> o_busy=0, o_load_ready=1, o_t_size=0; a following request returns 0.
